mimo_frame_serializer: RTL and testbench
========================================

# mimo_frame_serializer

Stream-side source for the 4x4 MIMO detector datapath. It accepts one complete frame (32-word channel matrix H plus 8-word receive vector Y) over a valid/ready handshake. It then emits the frame as four signed words per clock over a fixed 10-cycle slot, in the same word order the detector top level ingests. A free-running slot counter keeps slot alignment from reset. Slots with no pending frame carry an all-zero idle frame.

## Interface
- WL, 15, word length of every H/Y element (signed, two's complement)
- SLOT_LEN, 10, cycles per frame slot; fixed at 10 (8 H groups + 2 Y groups); other values unsupported
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high; clears all state
- h_i  in  32*WL  H frame; word n = h_i[n*WL +: WL], n = 0..31
- y_i  in  8*WL  Y frame; word m = y_i[m*WL +: WL], m = 0..7
- frame_valid_i  in  1  h_i/y_i hold a frame to send
- frame_ready_o  out  1  shadow buffer empty; a frame is accepted on any edge with valid & ready
- Out0, Out1, Out2, Out3  out  WL each  signed stream words for the current cycle
- valid_o  out  1  high for all 10 cycles of a slot carrying a real frame
- sof_o  out  1  high in slot cycle 0 of a real frame only
- frames_sent_o  out  16  count of real frames started, wraps at 2^16

## Operation
- State:
  - phase p, 0..9
  - active buffer, 40 words, plus active_real flag
  - shadow buffer, 40 words, plus shadow_full flag
  - frames_sent counter
- frame_ready_o = ~shadow_full. This is combinational from the flag and does not depend on frame_valid_i.
- Output mapping is driven only from registers (active, p):
  - p = 0..7: Outj = H word 4p+j
  - p = 8, 9: Outj = Y word 4(p-8)+j
- valid_o = active_real.
- sof_o = active_real & (p == 0).
- Every edge: p <= (p == 9) ? 0 : p + 1.
- Edge with p != 9: if frame_valid_i & frame_ready_o, the shadow buffer loads h_i/y_i and shadow_full <= 1.
- Edge with p == 9 (slot boundary), first match wins:
  - shadow_full: active <= shadow, active_real <= 1, shadow_full <= 0, frames_sent += 1. A frame offered on this edge is accepted only if ready was high before the edge, which it was not, so no accept occurs.
  - else frame_valid_i (ready = 1): bypass. Active <= h_i/y_i directly, active_real <= 1, frames_sent += 1, shadow stays empty.
  - else: active <= all zeros, active_real <= 0.
- frames_sent_o wraps 0xFFFF -> 0x0000 with no flag.

## Timing
- Reset (async, rst = 1), all outputs and state:
  - Out0..3 = 0, valid_o = 0, sof_o = 0, frames_sent_o = 0
  - frame_ready_o = 1, p = 0, active = 0, active_real = 0, shadow_full = 0
- First rising edge after rst falls moves p 0 -> 1. The first slot boundary is the edge leaving p = 9.
- Slot period is exactly 10 cycles, with no gaps and no stalls. Back-to-back frames are sustained only if each frame is accepted before the preceding slot boundary.
- Latency:
  - Accept on a p == 9 edge (bypass): sof_o is asserted on the very next cycle.
  - Accept on any other edge: sof_o is asserted in the cycle after the next p == 9 edge.
  - Worst case is 10 cycles from accept to sof_o.
- The shadow buffer is full for at most one slot. Ready returns high in the cycle after the transfer edge.
- Reset mid-slot:
  - The active and shadow frames are discarded.
  - Outputs go to zero immediately (asynchronous).
  - p restarts at 0, and slot alignment is re-derived from reset release.
- Input words pass through unmodified, with no saturation or sign change. Outputs are bit-exact copies of the accepted words.

## Test plan
- Reset check: hold rst = 1 and check all outputs at reset values. Release rst with frame_valid_i = 0 for 30 cycles -> valid_o = 0 and Out0..3 = 0 throughout; p wraps every 10 cycles, seen through a probe.
- Single frame: H word n = n+1 and Y word m = 100+m, accepted at p = 3 -> ready drops. At the next boundary: sof_o = 1 and Out0..3 = 1,2,3,4. Then 5..8, and so on through 29..32. Then 100..103 and 104..107. valid_o is high for exactly 10 cycles, and frames_sent_o = 1.
- Bypass: offer a frame only on a p == 9 edge -> sof_o is high in the next cycle, frame_ready_o stays 1, and the frame content is correct.
- Back-to-back: offer frames A, B, C as soon as ready -> three contiguous slots with no idle gap, sof_o exactly every 10 cycles, and frames_sent_o = 3.
- Back-pressure: hold frame_valid_i = 1 with changing data while shadow_full = 1 -> the shadow contents are unchanged and only the data present on the accept edge is emitted.
- Reset mid-frame: assert rst at slot cycle 5 with the shadow full -> outputs are 0 at once. After release, the following 20 cycles are idle and frames_sent_o = 0.

Source files
------------

// File: rtl/mimo_frame_serializer.sv
// mimo_frame_serializer
// Accepts one 40-word frame (32 H words + 8 Y words) over valid/ready and
// replays it four words per cycle across a fixed 10-cycle slot. A free-running
// phase counter defines slot alignment from reset; slots without a pending
// frame carry an all-zero idle frame with valid_o low.
module mimo_frame_serializer #(
    parameter int WL       = 15,
    parameter int SLOT_LEN = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*WL-1:0]     h_i,
    input  logic [8*WL-1:0]      y_i,
    input  logic                 frame_valid_i,
    output logic                 frame_ready_o,
    output logic signed [WL-1:0] Out0,
    output logic signed [WL-1:0] Out1,
    output logic signed [WL-1:0] Out2,
    output logic signed [WL-1:0] Out3,
    output logic                 valid_o,
    output logic                 sof_o,
    output logic [15:0]          frames_sent_o
);

    // H words occupy word slots 0..31 and Y words 32..39, so cycle p of a
    // slot always shows words 4p..4p+3 of this combined vector.
    localparam int         NWORDS     = 40;
    localparam int         FW         = NWORDS * WL;
    localparam logic [3:0] LAST_PHASE = 4'(SLOT_LEN - 1);

    logic [3:0]    phase_q, phase_d;
    logic [FW-1:0] active_q, active_d;
    logic          active_real_q, active_real_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic          shadow_full_q, shadow_full_d;
    logic [15:0]   frames_sent_q, frames_sent_d;

    logic [FW-1:0] frame_in;
    logic          slot_end;

    assign frame_in      = {y_i, h_i};
    assign slot_end      = (phase_q == LAST_PHASE);
    assign frame_ready_o = ~shadow_full_q;

    // Next-state: phase advance, shadow capture mid-slot, hand-off at slot end.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        phase_d       = slot_end ? 4'd0 : phase_q + 4'd1;
        active_d      = active_q;
        active_real_d = active_real_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        frames_sent_d = frames_sent_q;

        if (!slot_end) begin
            if (frame_valid_i && !shadow_full_q) begin
                shadow_d      = frame_in;
                shadow_full_d = 1'b1;
            end
        end else if (shadow_full_q) begin
            // A frame offered on this edge sees ready low, so it is not taken.
            active_d      = shadow_q;
            active_real_d = 1'b1;
            shadow_full_d = 1'b0;
            frames_sent_d = frames_sent_q + 16'd1;
        end else if (frame_valid_i) begin
            // Bypass: empty shadow at the boundary, so load active directly.
            active_d      = frame_in;
            active_real_d = 1'b1;
            frames_sent_d = frames_sent_q + 16'd1;
        end else begin
            active_d      = '0;
            active_real_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously so outputs drop to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 4'd0;
            // NOTE: both frame buffers are plain flops and are reset because idle output must read as zero.
            active_q      <= '0;
            active_real_q <= 1'b0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            frames_sent_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            phase_q       <= phase_d;
            active_q      <= active_d;
            active_real_q <= active_real_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    // Output mapping taken only from registered active buffer and phase.
    always_comb begin
        int base;
        base = int'(phase_q) * 4;
        Out0 = active_q[(base + 0) * WL +: WL];
        Out1 = active_q[(base + 1) * WL +: WL];
        Out2 = active_q[(base + 2) * WL +: WL];
        Out3 = active_q[(base + 3) * WL +: WL];
    end

    assign valid_o       = active_real_q;
    assign sof_o         = active_real_q & (phase_q == 4'd0);
    assign frames_sent_o = frames_sent_q;

endmodule

// File: tb/tb_mimo_frame_serializer.sv
// Directed bench for mimo_frame_serializer. Inputs change 1 ns after each
// rising edge and outputs are sampled in that same window; bp mirrors the
// slot phase the bench expects the DUT to hold in the current cycle.
module tb_mimo_frame_serializer;

    localparam int WL = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [32*WL-1:0]     h_i;
    logic [8*WL-1:0]      y_i;
    logic                 frame_valid_i;
    logic                 frame_ready_o;
    logic signed [WL-1:0] Out0, Out1, Out2, Out3;
    logic                 valid_o;
    logic                 sof_o;
    logic [15:0]          frames_sent_o;

    int checks   = 0;
    int failures = 0;
    int bp       = 0;

    mimo_frame_serializer #(.WL(WL), .SLOT_LEN(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .h_i           (h_i),
        .y_i           (y_i),
        .frame_valid_i (frame_valid_i),
        .frame_ready_o (frame_ready_o),
        .Out0          (Out0),
        .Out1          (Out1),
        .Out2          (Out2),
        .Out3          (Out3),
        .valid_o       (valid_o),
        .sof_o         (sof_o),
        .frames_sent_o (frames_sent_o)
    );

    always #5 clk = ~clk;

    // Seed 0: H word n = n+1, Y word m = 100+m. Other seeds: sign bit from
    // seed parity, seed in the middle bits, word index in the low byte.
    function automatic logic [WL-1:0] gen(input int seed, input int k);
        logic [31:0] s;
        logic [31:0] kk;
        s  = 32'(seed);
        kk = 32'(k);
        if (seed == 0) return (k < 32) ? WL'(k + 1) : WL'(100 + k - 32);
        return {s[0], s[5:0], kk[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bp = (bp == 9) ? 0 : bp + 1;
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 10 && bp != target; i++) tick();
    endtask

    task automatic drive_frame(input int seed);
        for (int k = 0; k < 40; k++) begin
            if (k < 32) h_i[k*WL +: WL] = gen(seed, k);
            else        y_i[(k-32)*WL +: WL] = gen(seed, k);
        end
    endtask

    // Compares one slot cycle (phase c) against frame 'seed' or the idle frame.
    task automatic observe_cycle(input string name, input int seed, input bit real_f, input int c);
        logic [WL-1:0] got [4];
        logic [WL-1:0] exp;
        got = '{Out0, Out1, Out2, Out3};
        for (int j = 0; j < 4; j++) begin
            exp = real_f ? gen(seed, 4*c + j) : '0;
            checks++;
            if (got[j] !== exp) begin
                failures++;
                $display("FAIL %s c%0d Out%0d: got %0h expected %0h", name, c, j, got[j], exp);
            end
        end
        checks++;
        if (valid_o !== real_f) begin
            failures++;
            $display("FAIL %s c%0d valid_o: got %b expected %b", name, c, valid_o, real_f);
        end
        checks++;
        if (sof_o !== (real_f && c == 0)) begin
            failures++;
            $display("FAIL %s c%0d sof_o: got %b expected %b", name, c, sof_o, real_f && c == 0);
        end
    endtask

    task automatic observe_slot(input string name, input int seed, input bit real_f);
        for (int c = 0; c < 10; c++) begin
            observe_cycle(name, seed, real_f, c);
            tick();
        end
    endtask

    task automatic expect_count(input string name, input logic [15:0] exp);
        checks++;
        if (frames_sent_o !== exp) begin
            failures++;
            $display("FAIL %s frames_sent_o: got %0d expected %0d", name, frames_sent_o, exp);
        end
    endtask

    task automatic expect_ready(input string name, input logic exp);
        checks++;
        if (frame_ready_o !== exp) begin
            failures++;
            $display("FAIL %s frame_ready_o: got %b expected %b", name, frame_ready_o, exp);
        end
    endtask

    task automatic idle_run(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            observe_cycle(name, 0, 1'b0, bp);
            expect_count(name, 16'd0);
            checks++;
            if (dut.phase_q !== 4'(bp)) begin
                failures++;
                $display("FAIL %s phase probe: got %0d expected %0d", name, dut.phase_q, bp);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_valid_i = 1'b0;
        h_i = '0;
        y_i = '0;
        #12;
        observe_cycle("reset", 0, 1'b0, 0);
        expect_count("reset", 16'd0);
        expect_ready("reset", 1'b1);
        tick();
        rst = 1'b0;
        bp = 0;
        idle_run("reset_idle", 30);
    endtask

    task automatic test_single_frame();
        wait_phase(3);
        drive_frame(0);
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        drive_frame(63);
        expect_ready("single_accept", 1'b0);
        wait_phase(0);
        expect_ready("single_after_xfer", 1'b1);
        observe_slot("single", 0, 1'b1);
        expect_count("single", 16'd1);
        observe_cycle("single_after", 0, 1'b0, 0);
    endtask

    task automatic test_bypass();
        wait_phase(9);
        drive_frame(5);
        expect_ready("bypass_pre", 1'b1);
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        expect_ready("bypass_post", 1'b1);
        observe_slot("bypass", 5, 1'b1);
        expect_count("bypass", 16'd2);
    endtask

    // Frames 7, 8, 9 offered at phase 0 of consecutive slots; each appears
    // in the following slot, giving three contiguous real slots.
    task automatic test_back_to_back();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 10; c++) begin
                if (c == 0 && s < 3) begin
                    expect_ready("b2b_offer", 1'b1);
                    drive_frame(7 + s);
                    frame_valid_i = 1'b1;
                end else begin
                    frame_valid_i = 1'b0;
                end
                observe_cycle("b2b", 7 + s - 1, s > 0, c);
                tick();
            end
        end
        // Two frames were sent before this scenario.
        expect_count("b2b", 16'd5);
    endtask

    task automatic test_back_pressure();
        wait_phase(2);
        drive_frame(20);
        frame_valid_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            drive_frame(21 + i);
            expect_ready("bp_hold", 1'b0);
            tick();
        end
        frame_valid_i = 1'b0;
        observe_slot("back_pressure", 20, 1'b1);
        expect_count("back_pressure", 16'd6);
        observe_cycle("bp_after", 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        wait_phase(9);
        drive_frame(31);
        frame_valid_i = 1'b1;
        tick();
        drive_frame(30);
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        wait_phase(5);
        observe_cycle("mid_pre", 31, 1'b1, 5);
        expect_ready("mid_pre", 1'b0);
        expect_count("mid_pre", 16'd7);
        #2;
        rst = 1'b1;
        #1;
        observe_cycle("mid_rst", 0, 1'b0, 0);
        expect_ready("mid_rst", 1'b1);
        expect_count("mid_rst", 16'd0);
        tick();
        tick();
        rst = 1'b0;
        bp = 0;
        idle_run("mid_idle", 20);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bypass();
        test_back_to_back();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
